seg_scan_mux: RTL and testbench

SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

---
 rtl/seg_scan_pkg.sv | 30 +++
 rtl/seg_scan_mux_timer.sv | 34 +++
 rtl/seg_scan_mux.sv | 123 ++++++++++++
 tb/tb_seg_scan_mux.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the two-digit segment scan multiplexer.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        GAP0 = 2'd1,
        DIG1 = 2'd2,
        GAP1 = 2'd3
    } scan_state_e;

    localparam logic [6:0]  SEG_OFF  = 7'h7F;
    localparam logic [1:0]  AN_OFF   = 2'b11;
    localparam logic [1:0]  AN_DIG0  = 2'b10;
    localparam logic [1:0]  AN_DIG1  = 2'b01;
    localparam logic [13:0] DISP_OFF = 14'h3FFF;

    function automatic scan_state_e next_state(input scan_state_e s);
        case (s)
            DIG0:    return GAP0;
            GAP0:    return DIG1;
            DIG1:    return GAP1;
            default: return DIG0;
        endcase
    endfunction

    function automatic logic is_digit(input scan_state_e s);
        return (s == DIG0) || (s == DIG1);
    endfunction

endpackage

// File: rtl/seg_scan_mux_timer.sv
// Loadable down-counter with a zero flag; holds at zero until reloaded.
module scan_timer #(
    parameter int             W       = 16,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/seg_scan_mux.sv
// Two-digit multiplexed 7-segment driver with a one-deep pending pattern
// register that is committed to the display only at the end of each frame.
//
// state | meaning
// DIG0  | digit 0 (units) lit, DIV_CYCLES long
// GAP0  | all off after digit 0, GAP_CYCLES long
// DIG1  | digit 1 (sign/tens) lit, DIV_CYCLES long
// GAP1  | all off after digit 1; its last cycle is the frame boundary
module seg_scan_mux
    import seg_scan_pkg::*;
#(
    parameter int DIV_CYCLES = 50000,
    parameter int GAP_CYCLES = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] pat_in,
    input  logic        pat_valid,
    output logic        pat_ready,
    input  logic        blank_en,
    output logic [6:0]  seg_n,
    output logic [1:0]  an_n
);

    localparam int MAX_CYCLES = (DIV_CYCLES > GAP_CYCLES) ? DIV_CYCLES : GAP_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] DIV_LD = CW'(DIV_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LD = CW'(GAP_CYCLES - 1);

    scan_state_e  state_q, state_d;
    logic [13:0]  disp_q, disp_d;
    logic [13:0]  pend_q, pend_d;
    logic         pend_full_q, pend_full_d;
    logic         ready_q, ready_d;
    logic [6:0]   seg_q, seg_d;
    logic [1:0]   an_q, an_d;

    logic          tmr_zero;
    logic [CW-1:0] tmr_load_val;
    logic          accept;
    logic          boundary;

    scan_timer #(
        .W       (CW),
        .RST_VAL (GAP_LD)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_zero),
        .load_val_i (tmr_load_val),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d     = state_q;
        disp_d      = disp_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        seg_d       = SEG_OFF;
        an_d        = AN_OFF;

        accept   = pat_valid && ready_q;
        boundary = (state_q == GAP1) && tmr_zero;

        if (tmr_zero) begin
            state_d = next_state(state_q);
        end
        tmr_load_val = is_digit(state_d) ? DIV_LD : GAP_LD;

        // Commit and accept are exclusive: accept needs an empty slot, commit a full one.
        if (boundary && pend_full_q) begin
            disp_d      = pend_q;
            pend_full_d = 1'b0;
        end else if (accept) begin
            pend_d      = pat_in;
            pend_full_d = 1'b1;
        end
        ready_d = !pend_full_d;

        // Outputs are computed from next-state values so the registers track the live state.
        if (!blank_en) begin
            case (state_d)
                DIG0: begin
                    an_d  = AN_DIG0;
                    seg_d = disp_d[6:0];
                end
                DIG1: begin
                    an_d  = AN_DIG1;
                    seg_d = disp_d[13:7];
                end
                default: begin
                    an_d  = AN_OFF;
                    seg_d = SEG_OFF;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= GAP1;
            disp_q      <= DISP_OFF;
            pend_q      <= DISP_OFF;
            pend_full_q <= 1'b0;
            ready_q     <= 1'b1;
            seg_q       <= SEG_OFF;
            an_q        <= AN_OFF;
        end else begin
            state_q     <= state_d;
            disp_q      <= disp_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            ready_q     <= ready_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    assign pat_ready = ready_q;
    assign seg_n     = seg_q;
    assign an_n      = an_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux with a frame-position reference model.
module tb_seg_scan_mux;

    localparam int D = 4;
    localparam int G = 2;
    localparam int F = 2 * (D + G);

    localparam logic [13:0] PA = 14'b10000001111001;
    localparam logic [13:0] PB = 14'b01111110100100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [13:0] pat_in = '0;
    logic        pat_valid = 1'b0;
    logic        blank_en = 1'b0;
    logic        pat_ready;
    logic [6:0]  seg_n;
    logic [1:0]  an_n;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    seg_scan_mux #(
        .DIV_CYCLES (D),
        .GAP_CYCLES (G)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pat_in    (pat_in),
        .pat_valid (pat_valid),
        .pat_ready (pat_ready),
        .blank_en  (blank_en),
        .seg_n     (seg_n),
        .an_n      (an_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d, t=%0t)", nm, act, want, cyc, $time);
        end
    endtask

    // Reference model: position within the 12-cycle frame, counted from reset release.
    // Frame layout from release: GAP1 [0,G), DIG0 [G,G+D), GAP0, DIG1 [2G+D,F).
    logic        m_ok = 1'b0;
    int          m_t;
    logic [13:0] m_disp, m_pend;
    logic        m_full;
    logic        m_blk;

    function automatic logic [1:0] exp_an(input int t, input logic blk);
        int p;
        p = t % F;
        if (blk) return 2'b11;
        if (p >= G && p < G + D) return 2'b10;
        if (p >= 2 * G + D) return 2'b01;
        return 2'b11;
    endfunction

    function automatic logic [6:0] exp_seg(input int t, input logic [13:0] d, input logic blk);
        int p;
        p = t % F;
        if (blk) return 7'h7F;
        if (p >= G && p < G + D) return d[6:0];
        if (p >= 2 * G + D) return d[13:7];
        return 7'h7F;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ok   <= 1'b1;
            m_t    <= 0;
            m_disp <= 14'h3FFF;
            m_pend <= 14'h3FFF;
            m_full <= 1'b0;
            m_blk  <= 1'b0;
        end else begin
            m_t   <= m_t + 1;
            m_blk <= blank_en;
            if ((m_t % F) == G - 1 && m_full) begin
                m_disp <= m_pend;
                m_full <= 1'b0;
            end else if (pat_valid && !m_full) begin
                m_pend <= pat_in;
                m_full <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("cmp_an", an_n, exp_an(m_t, m_blk));
            chk("cmp_seg", seg_n, exp_seg(m_t, m_disp, m_blk));
            chk("cmp_ready", pat_ready, !m_full);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) next_cycle();
    endtask

    task automatic boot_checks();
        for (int i = 0; i < 6; i++) begin
            chk("boot_an", an_n, (i < 2) ? 2'b11 : 2'b10);
            chk("boot_seg", seg_n, 7'h7F);
            chk("boot_ready", pat_ready, 1'b1);
            next_cycle();
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_an", an_n, 2'b11);
        chk("rst_seg", seg_n, 7'h7F);
        chk("rst_ready", pat_ready, 1'b1);
        rst_n = 1'b1;
        cyc = 0;
        boot_checks();

        pat_in = PA;
        pat_valid = 1'b1;
        next_cycle();
        chk("acc_ready_low", pat_ready, 1'b0);
        pat_in = PB;
        run_to(10);
        pat_valid = 1'b0;
        run_to(11);
        chk("pre_commit_an", an_n, 2'b01);
        chk("pre_commit_seg", seg_n, 7'h7F);
        run_to(13);
        chk("boundary_ready", pat_ready, 1'b0);
        chk("boundary_an", an_n, 2'b11);
        run_to(14);
        chk("dig0_an", an_n, 2'b10);
        chk("dig0_seg", seg_n, 7'b1111001);
        chk("post_commit_ready", pat_ready, 1'b1);
        run_to(20);
        chk("dig1_an", an_n, 2'b01);
        chk("dig1_seg", seg_n, 7'b1000000);

        run_to(31);
        blank_en = 1'b1;
        run_to(32);
        chk("blank_an", an_n, 2'b11);
        chk("blank_seg", seg_n, 7'h7F);
        run_to(34);
        blank_en = 1'b0;
        chk("blank_hold_an", an_n, 2'b11);
        run_to(35);
        chk("unblank_an", an_n, 2'b01);
        chk("unblank_seg", seg_n, 7'b1000000);
        run_to(38);
        chk("sched_dig0_an", an_n, 2'b10);
        chk("sched_dig0_seg", seg_n, 7'b1111001);

        run_to(49);
        chk("edge_load_an", an_n, 2'b11);
        pat_in = PB;
        pat_valid = 1'b1;
        run_to(50);
        pat_valid = 1'b0;
        chk("edge_ready_low", pat_ready, 1'b0);
        chk("edge_not_yet", seg_n, 7'b1111001);
        run_to(61);
        chk("edge_still_pend", pat_ready, 1'b0);
        run_to(62);
        chk("edge_commit_seg", seg_n, 7'b0100100);
        chk("edge_commit_ready", pat_ready, 1'b1);

        run_to(63);
        pat_in = PA;
        pat_valid = 1'b1;
        run_to(64);
        pat_valid = 1'b0;
        chk("pend_again", pat_ready, 1'b0);
        run_to(68);
        chk("pre_rst_dig1", seg_n, 7'b0111111);
        run_to(69);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_an", an_n, 2'b11);
        chk("async_rst_seg", seg_n, 7'h7F);
        chk("async_rst_ready", pat_ready, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
        boot_checks();
        run_to(8);
        chk("rst_dig1_dark", seg_n, 7'h7F);
        chk("rst_dig1_an", an_n, 2'b01);
        run_to(14);
        chk("rst_discard_seg", seg_n, 7'h7F);
        chk("rst_discard_ready", pat_ready, 1'b1);
        run_to(16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
